// File: rtl/np_mm_sequencer_if.sv
// Bundle between np_mm_sequencer and its surroundings: frame-buffer status,
// buffer read address, MAC enable/sum, and the valid/ready result port.
interface np_mm_sequencer_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_BUF    = 2,
    parameter int OUT_WIDTH  = 32
) ();
    logic [NUM_BUF-1:0]    frame_rdy;
    logic [OUT_WIDTH-1:0]  mac_sum;
    logic                  out_rdy;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [NUM_BUF-1:0]    reading_frame;
    logic                  mac_en;
    logic [NUM_BUF-1:0]    frame_done;
    logic [OUT_WIDTH-1:0]  result;
    logic                  result_val;

    modport master (
        input  frame_rdy, mac_sum, out_rdy,
        output buf_addr, reading_frame, mac_en, frame_done, result, result_val
    );

    modport slave (
        output frame_rdy, mac_sum, out_rdy,
        input  buf_addr, reading_frame, mac_en, frame_done, result, result_val
    );
endinterface

// File: rtl/np_mm_sequencer.sv
// Sequencer feeding np_matrix_mult: walks one VEC_LEN dot product per frame,
// captures the MAC sum into a single-entry valid/ready register, rotates buffers.
module np_mm_sequencer #(
    parameter int VEC_LEN    = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_BUF    = 2,
    parameter int OUT_WIDTH  = 32
) (
    input  logic              clock,
    input  logic              reset,
    np_mm_sequencer_if.master bus
);

    typedef enum logic [1:0] {IDLE, RUN, TAIL, CAPT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VEC_LEN - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  sel_rdy;

    logic                  mac_en_p1;
    logic [NUM_BUF-1:0]    reading_frame_q;
    logic [NUM_BUF-1:0]    frame_done_p2;
    logic [OUT_WIDTH-1:0]  result_p2;
    logic                  vld_p2;

    function automatic logic [NUM_BUF-1:0] rotl1(input logic [NUM_BUF-1:0] v);
        return {v[NUM_BUF-2:0], v[NUM_BUF-1]};
    endfunction

    // Only the selected buffer may start a frame, and never over a pending result.
    assign sel_rdy = (|(bus.frame_rdy & reading_frame_q)) && (!vld_p2 || bus.out_rdy);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (sel_rdy) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (cnt == LAST) state_nxt = TAIL;
                else             cnt_nxt   = cnt + ADDR_WIDTH'(1);
            end
            TAIL:    state_nxt = CAPT;
            CAPT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // p1: enable lines up with buffer data one cycle after the address.
    // p2: result capture once the last product has landed in mac_sum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mac_en_p1       <= 1'b0;
            reading_frame_q <= NUM_BUF'(1);
            frame_done_p2   <= '0;
            result_p2       <= '0;
            vld_p2          <= 1'b0;
        end else begin
            mac_en_p1     <= (state == RUN);
            frame_done_p2 <= '0;
            if (state == CAPT) begin
                result_p2       <= bus.mac_sum;
                vld_p2          <= 1'b1;
                frame_done_p2   <= reading_frame_q;
                reading_frame_q <= rotl1(reading_frame_q);
            end else if (vld_p2 && bus.out_rdy) begin
                vld_p2 <= 1'b0;
            end
        end
    end

    assign bus.buf_addr      = (state == RUN) ? cnt : '0;
    assign bus.reading_frame = reading_frame_q;
    assign bus.mac_en        = mac_en_p1;
    assign bus.frame_done    = frame_done_p2;
    assign bus.result        = result_p2;
    assign bus.result_val    = vld_p2;

endmodule

// File: tb/tb_np_mm_sequencer.sv
// Directed bench for np_mm_sequencer: VEC_LEN=4 and VEC_LEN=1 instances, each
// driving a behavioural 1-cycle-read buffer pair and clear-on-idle MAC.
module tb_np_mm_sequencer;

    logic clock;
    logic reset_n;

    np_mm_sequencer_if #(.ADDR_WIDTH(2), .NUM_BUF(2), .OUT_WIDTH(32)) bus_a ();
    np_mm_sequencer_if #(.ADDR_WIDTH(2), .NUM_BUF(2), .OUT_WIDTH(32)) bus_b ();

    np_mm_sequencer #(.VEC_LEN(4), .ADDR_WIDTH(2), .NUM_BUF(2), .OUT_WIDTH(32)) dut_a (
        .clock (clock),
        .reset (reset_n),
        .bus   (bus_a)
    );

    np_mm_sequencer #(.VEC_LEN(1), .ADDR_WIDTH(2), .NUM_BUF(2), .OUT_WIDTH(32)) dut_b (
        .clock (clock),
        .reset (reset_n),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] feat_a [0:1][0:3];
    logic [31:0] wt_a   [0:1][0:3];
    logic [31:0] fq_a, wq_a, sum_a;
    logic [31:0] feat_b [0:1][0:3];
    logic [31:0] wt_b   [0:1][0:3];
    logic [31:0] fq_b, wq_b, sum_b;

    always @(posedge clock) begin
        fq_a  <= feat_a[bus_a.reading_frame[1]][bus_a.buf_addr];
        wq_a  <= wt_a[bus_a.reading_frame[1]][bus_a.buf_addr];
        sum_a <= bus_a.mac_en ? sum_a + fq_a * wq_a : 32'd0;
        fq_b  <= feat_b[bus_b.reading_frame[1]][bus_b.buf_addr];
        wq_b  <= wt_b[bus_b.reading_frame[1]][bus_b.buf_addr];
        sum_b <= bus_b.mac_en ? sum_b + fq_b * wq_b : 32'd0;
    end

    assign bus_a.mac_sum = sum_a;
    assign bus_b.mac_sum = sum_b;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                feat_a[b][i] = 32'((i + 1) * (b + 1));
                wt_a[b][i]   = 32'd1;
                feat_b[b][i] = 32'd0;
                wt_b[b][i]   = 32'd0;
            end
        end
        feat_b[0][0] = 32'h7FFF_FFFF;
        wt_b[0][0]   = 32'd2;

        reset_n         = 1'b0;
        bus_a.frame_rdy = 2'b00;
        bus_a.out_rdy   = 1'b1;
        bus_b.frame_rdy = 2'b00;
        bus_b.out_rdy   = 1'b1;
        repeat (3) tick();

        chk("rst_buf_addr",   64'(bus_a.buf_addr),      64'd0);
        chk("rst_rframe",     64'(bus_a.reading_frame), 64'd1);
        chk("rst_mac_en",     64'(bus_a.mac_en),        64'd0);
        chk("rst_frame_done", 64'(bus_a.frame_done),    64'd0);
        chk("rst_result",     64'(bus_a.result),        64'd0);
        chk("rst_result_val", 64'(bus_a.result_val),    64'd0);
        reset_n = 1'b1;
        tick();

        // Single frame; frame_rdy dropped mid-frame must not abort it.
        bus_a.frame_rdy = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t1_addr",  64'(bus_a.buf_addr),      (k <= 4) ? 64'(k - 1) : 64'd0);
            chk("t1_en",    64'(bus_a.mac_en),        64'(k >= 2 && k <= 5));
            chk("t1_val",   64'(bus_a.result_val),    64'(k == 7));
            chk("t1_done",  64'(bus_a.frame_done),    (k == 7) ? 64'd1 : 64'd0);
            chk("t1_frame", 64'(bus_a.reading_frame), (k >= 7) ? 64'd2 : 64'd1);
            if (k == 7) chk("t1_result", 64'(bus_a.result), 64'd10);
            if (k == 2) bus_a.frame_rdy = 2'b00;
        end

        // Ping-pong, back to back at the minimum period.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        bus_a.frame_rdy = 2'b11;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 7) begin
                chk("pp_res1",   64'(bus_a.result),        64'd10);
                chk("pp_val1",   64'(bus_a.result_val),    64'd1);
                chk("pp_frame1", 64'(bus_a.reading_frame), 64'd2);
                chk("pp_done1",  64'(bus_a.frame_done),    64'd1);
            end
            if (k == 8)  chk("pp_en_off", 64'(bus_a.mac_en), 64'd0);
            if (k == 9)  chk("pp_en_on",  64'(bus_a.mac_en), 64'd1);
            if (k == 8 || k == 13 || k == 15) chk("pp_val0", 64'(bus_a.result_val), 64'd0);
            if (k == 14) begin
                chk("pp_res2",   64'(bus_a.result),        64'd20);
                chk("pp_val2",   64'(bus_a.result_val),    64'd1);
                chk("pp_frame2", 64'(bus_a.reading_frame), 64'd1);
                chk("pp_done2",  64'(bus_a.frame_done),    64'd2);
                bus_a.frame_rdy = 2'b00;
            end
        end

        // Back-pressure: pending result blocks the next start.
        bus_a.out_rdy   = 1'b0;
        bus_a.frame_rdy = 2'b11;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 7) begin
                chk("bp_val1", 64'(bus_a.result_val), 64'd1);
                chk("bp_res1", 64'(bus_a.result),     64'd10);
            end
            if (k >= 8 && k <= 10) begin
                chk("bp_hold_val",  64'(bus_a.result_val), 64'd1);
                chk("bp_hold_res",  64'(bus_a.result),     64'd10);
                chk("bp_hold_addr", 64'(bus_a.buf_addr),   64'd0);
                chk("bp_hold_en",   64'(bus_a.mac_en),     64'd0);
            end
            if (k == 10) bus_a.out_rdy = 1'b1;
            if (k == 11) begin
                chk("bp_accept", 64'(bus_a.result_val), 64'd0);
                chk("bp_addr0",  64'(bus_a.buf_addr),   64'd0);
                bus_a.out_rdy = 1'b0;
            end
            if (k == 12) begin
                chk("bp_addr1", 64'(bus_a.buf_addr), 64'd1);
                chk("bp_en",    64'(bus_a.mac_en),   64'd1);
            end
            if (k == 17) begin
                chk("bp_val2",   64'(bus_a.result_val),    64'd1);
                chk("bp_res2",   64'(bus_a.result),        64'd20);
                chk("bp_frame2", 64'(bus_a.reading_frame), 64'd1);
                bus_a.frame_rdy = 2'b00;
                bus_a.out_rdy   = 1'b1;
            end
            if (k == 18) chk("bp_val_clr", 64'(bus_a.result_val), 64'd0);
        end

        // Rotation order: only the selected buffer may start.
        bus_a.frame_rdy = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3 || k == 5) begin
                chk("rot_idle_en",   64'(bus_a.mac_en),   64'd0);
                chk("rot_idle_addr", 64'(bus_a.buf_addr), 64'd0);
            end
            if (k == 5) bus_a.frame_rdy = 2'b01;
            if (k == 7) chk("rot_addr1", 64'(bus_a.buf_addr), 64'd1);
            if (k == 12) begin
                chk("rot_val",   64'(bus_a.result_val),    64'd1);
                chk("rot_res",   64'(bus_a.result),        64'd10);
                chk("rot_frame", 64'(bus_a.reading_frame), 64'd2);
                bus_a.frame_rdy = 2'b00;
            end
        end

        // Asynchronous reset during RUN at cnt=2.
        bus_a.frame_rdy = 2'b10;
        repeat (3) tick();
        chk("mr_addr2", 64'(bus_a.buf_addr), 64'd2);
        reset_n = 1'b0;
        #1;
        chk("mr_addr",   64'(bus_a.buf_addr),      64'd0);
        chk("mr_frame",  64'(bus_a.reading_frame), 64'd1);
        chk("mr_en",     64'(bus_a.mac_en),        64'd0);
        chk("mr_done",   64'(bus_a.frame_done),    64'd0);
        chk("mr_result", 64'(bus_a.result),        64'd0);
        chk("mr_val",    64'(bus_a.result_val),    64'd0);
        bus_a.frame_rdy = 2'b00;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("mr_no_done", 64'(bus_a.frame_done), 64'd0);
        end
        bus_a.frame_rdy = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 7) begin
                chk("mr_res", 64'(bus_a.result),     64'd10);
                chk("mr_vld", 64'(bus_a.result_val), 64'd1);
                chk("mr_fd",  64'(bus_a.frame_done), 64'd1);
                bus_a.frame_rdy = 2'b00;
            end
        end

        // VEC_LEN=1 with a wrapping MAC sum.
        bus_b.frame_rdy = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) begin
                chk("v1_addr", 64'(bus_b.buf_addr), 64'd0);
                chk("v1_en1",  64'(bus_b.mac_en),   64'd0);
                bus_b.frame_rdy = 2'b00;
            end
            if (k == 2) chk("v1_en2", 64'(bus_b.mac_en), 64'd1);
            if (k == 3) begin
                chk("v1_en3",  64'(bus_b.mac_en),     64'd0);
                chk("v1_val3", 64'(bus_b.result_val), 64'd0);
            end
            if (k == 4) begin
                chk("v1_val",   64'(bus_b.result_val),    64'd1);
                chk("v1_res",   64'(bus_b.result),        64'hFFFF_FFFE);
                chk("v1_done",  64'(bus_b.frame_done),    64'd1);
                chk("v1_frame", 64'(bus_b.reading_frame), 64'd2);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
